multi_trigger: RTL and testbench

Parametrised multi-channel camera trigger generator. It is the successor to the single-channel IMU-decimated trigger.
- Derives a frame start from IMU sync pulses (decimated) or from an internal period timer.
- Drives NUM_CH independent trigger lines, each with its own enable, start delay and exposure width in microseconds.
- Reports a frame counter and per-channel overrun flags.
- Sits between the IMU/register interface and the image-sensor trigger pins.

---
 rtl/ovc_trig_pkg.sv | 17 +
 rtl/trigger_channel.sv | 95 +++++++++
 rtl/multi_trigger.sv | 115 +++++++++++
 tb/tb_multi_trigger.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ovc_trig_pkg.sv
// Shared types and default sizing for the multi-channel camera trigger.
package ovc_trig_pkg;

  // Per-channel trigger state
  typedef enum logic [1:0] {
    TRIG_IDLE   = 2'd0,
    TRIG_DELAY  = 2'd1,
    TRIG_ACTIVE = 2'd2
  } trig_state_e;

  // Default build parameters
  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_CLK_PER_USEC = 125;
  localparam int DEF_DECIM_W      = 8;
  localparam int DEF_EXP_W        = 16;

endpackage

// File: rtl/trigger_channel.sv
// One trigger line: waits the latched delay, then holds its output high for
// the latched exposure, both counted in microsecond ticks.
module trigger_channel
  import ovc_trig_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W
) (
  input  logic             c,
  input  logic             rst_n,
  input  logic             usec_tick_i,
  input  logic             frame_start_i,
  input  logic             en_i,
  input  logic [EXP_W-1:0] delay_i,
  input  logic [EXP_W-1:0] exposure_i,
  input  logic             overrun_clr_i,
  output logic             q_o,
  output logic             overrun_o,
  output logic             busy_o
);

  localparam logic [EXP_W-1:0] ONE_USEC = EXP_W'(1);

  trig_state_e      state_q;
  logic [EXP_W-1:0] delay_q;
  logic [EXP_W-1:0] exposure_q;
  logic [EXP_W-1:0] cnt_q;
  logic             q_q;
  logic             overrun_q;
  logic             start_ok;

  // A zero exposure or a disabled channel never leaves IDLE
  assign start_ok = en_i && (exposure_i != '0);

  // Channel FSM with latched config, usec counter and registered outputs
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TRIG_IDLE;
      delay_q    <= '0;
      exposure_q <= '0;
      cnt_q      <= '0;
      q_q        <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      q_q <= (state_q == TRIG_ACTIVE);

      // A new frame while still busy is reported, never restarts the pulse;
      // set has priority over clear.
      if (frame_start_i && (state_q != TRIG_IDLE)) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr_i) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        TRIG_IDLE: begin
          if (frame_start_i && start_ok) begin
            delay_q    <= delay_i;
            exposure_q <= exposure_i;
            cnt_q      <= '0;
            state_q    <= (delay_i == '0) ? TRIG_ACTIVE : TRIG_DELAY;
          end
        end
        TRIG_DELAY: begin
          if (usec_tick_i) begin
            if (cnt_q == delay_q - ONE_USEC) begin
              cnt_q   <= '0;
              state_q <= TRIG_ACTIVE;
            end else begin
              cnt_q <= cnt_q + ONE_USEC;
            end
          end
        end
        TRIG_ACTIVE: begin
          if (usec_tick_i) begin
            if (cnt_q == exposure_q - ONE_USEC) begin
              cnt_q   <= '0;
              state_q <= TRIG_IDLE;
            end else begin
              cnt_q <= cnt_q + ONE_USEC;
            end
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= TRIG_IDLE;
        end
      endcase
    end
  end

  assign q_o       = q_q;
  assign overrun_o = overrun_q;
  assign busy_o    = (state_q != TRIG_IDLE);

endmodule

// File: rtl/multi_trigger.sv
// Multi-channel camera trigger: usec prescaler, internal period timer, IMU
// sync decimator and frame counter feeding NUM_CH trigger channels.
module multi_trigger
  import ovc_trig_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int CLK_PER_USEC = DEF_CLK_PER_USEC,
  parameter int DECIM_W      = DEF_DECIM_W,
  parameter int EXP_W        = DEF_EXP_W
) (
  input  logic                    c,
  input  logic                    rst_n,
  input  logic                    imu_sync,
  input  logic                    mode_internal,
  input  logic [EXP_W-1:0]        period_usec,
  input  logic [DECIM_W-1:0]      imu_decim,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*EXP_W-1:0] delay_usec,
  input  logic [NUM_CH*EXP_W-1:0] exposure_usec,
  input  logic                    overrun_clr,
  output logic [NUM_CH-1:0]       q,
  output logic                    frame_start,
  output logic [15:0]             frame_cnt,
  output logic [NUM_CH-1:0]       overrun,
  output logic                    busy
);

  localparam int PRESC_W = (CLK_PER_USEC > 1) ? $clog2(CLK_PER_USEC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_USEC - 1);
  localparam logic [EXP_W-1:0]   ONE_USEC   = EXP_W'(1);

  logic [PRESC_W-1:0] presc_q;
  logic [EXP_W-1:0]   per_cnt_q;
  logic [DECIM_W-1:0] dec_cnt_q;
  logic               frame_start_q;
  logic [15:0]        frame_cnt_q;

  logic               usec_tick;
  logic               int_sync;
  logic               sync;
  logic               fire;
  logic [NUM_CH-1:0]  ch_busy;

  assign usec_tick = (presc_q == PRESC_LAST);

  // Free-running prescaler producing one tick per microsecond
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= usec_tick ? '0 : presc_q + PRESC_W'(1);
    end
  end

  // Reload at period-1 or above so that lowering period_usec on the fly
  // never lets the counter run away to a full wrap.
  assign int_sync = usec_tick && (period_usec != '0) &&
                    (per_cnt_q >= period_usec - ONE_USEC);

  // Internal period timer, held at zero while the period is zero
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q <= '0;
    end else if (period_usec == '0) begin
      per_cnt_q <= '0;
    end else if (int_sync) begin
      per_cnt_q <= '0;
    end else if (usec_tick) begin
      per_cnt_q <= per_cnt_q + ONE_USEC;
    end
  end

  assign sync = mode_internal ? int_sync : imu_sync;
  assign fire = sync && (dec_cnt_q >= imu_decim);

  // Sync decimator plus registered frame start pulse and frame counter
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt_q     <= '0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      if (sync) begin
        dec_cnt_q <= fire ? '0 : dec_cnt_q + DECIM_W'(1);
      end
      frame_start_q <= fire;
      if (fire) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    trigger_channel #(
      .EXP_W(EXP_W)
    ) u_ch (
      .c            (c),
      .rst_n        (rst_n),
      .usec_tick_i  (usec_tick),
      .frame_start_i(frame_start_q),
      .en_i         (ch_en[gi]),
      .delay_i      (delay_usec[gi*EXP_W +: EXP_W]),
      .exposure_i   (exposure_usec[gi*EXP_W +: EXP_W]),
      .overrun_clr_i(overrun_clr),
      .q_o          (q[gi]),
      .overrun_o    (overrun[gi]),
      .busy_o       (ch_busy[gi])
    );
  end

  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;
  assign busy        = |ch_busy;

endmodule

// File: tb/tb_multi_trigger.sv
`timescale 1ns/1ps
// Bench for multi_trigger: table-driven single-frame vectors, hand-written
// multi-cycle sequences and a randomized run against a timestamp model.
module tb_multi_trigger;
  localparam int NCH = 4;
  localparam int CPU = 5;
  localparam int DW  = 8;
  localparam int EW  = 16;

  logic              c = 1'b0;
  logic              rst_n = 1'b0;
  logic              imu_sync = 1'b0;
  logic              mode_internal = 1'b0;
  logic [EW-1:0]     period_usec = '0;
  logic [DW-1:0]     imu_decim = '0;
  logic [NCH-1:0]    ch_en = '0;
  logic [NCH*EW-1:0] delay_usec = '0;
  logic [NCH*EW-1:0] exposure_usec = '0;
  logic              overrun_clr = 1'b0;
  logic [NCH-1:0]    q;
  logic              frame_start;
  logic [15:0]       frame_cnt;
  logic [NCH-1:0]    overrun;
  logic              busy;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int base = 0;

  // measurement state for channel 0 and frame_start
  int   m_rise, m_nrise, m_lastw, m_w, m_nfs, m_lastfs;
  logic m_prev;

  multi_trigger #(
    .NUM_CH(NCH), .CLK_PER_USEC(CPU), .DECIM_W(DW), .EXP_W(EW)
  ) dut (
    .c(c), .rst_n(rst_n), .imu_sync(imu_sync), .mode_internal(mode_internal),
    .period_usec(period_usec), .imu_decim(imu_decim), .ch_en(ch_en),
    .delay_usec(delay_usec), .exposure_usec(exposure_usec),
    .overrun_clr(overrun_clr), .q(q), .frame_start(frame_start),
    .frame_cnt(frame_cnt), .overrun(overrun), .busy(busy)
  );

  always #5 c = ~c;
  always @(posedge c) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vec_cnt++;
    if (act !== exp_v) begin
      err_cnt++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp_v);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    vec_cnt++;
    if (act < lo || act > hi) begin
      err_cnt++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d..%0d", name, cyc, act, lo, hi);
    end
  endtask

  task automatic do_reset();
    @(negedge c);
    rst_n = 1'b0;
    imu_sync = 1'b0; overrun_clr = 1'b0; mode_internal = 1'b0;
    period_usec = '0; imu_decim = '0; ch_en = '0;
    delay_usec = '0; exposure_usec = '0;
    @(negedge c);
    @(negedge c);
    rst_n = 1'b1;
    base = cyc;
  endtask

  task automatic set_ch(input int i, input logic en, input int d, input int e);
    ch_en[i] = en;
    delay_usec[i*EW +: EW] = EW'(d);
    exposure_usec[i*EW +: EW] = EW'(e);
  endtask

  task automatic rand_ch(input int i);
    ch_en[i] = ($urandom_range(0, 4) != 0);
    delay_usec[i*EW +: EW] = EW'($urandom_range(0, 3));
    exposure_usec[i*EW +: EW] = EW'($urandom_range(0, 3));
  endtask

  task automatic clr_meas();
    m_rise = -1; m_nrise = 0; m_lastw = 0; m_w = 0;
    m_nfs = 0; m_lastfs = -1; m_prev = 1'b0;
  endtask

  task automatic sample0();
    if (q[0] && !m_prev) begin
      if (m_nrise == 0) m_rise = cyc;
      m_nrise++;
      m_w = 0;
    end
    if (q[0]) m_w++;
    if (!q[0] && m_prev) m_lastw = m_w;
    m_prev = q[0];
    if (frame_start) begin
      m_nfs++;
      m_lastfs = cyc;
    end
  endtask

  // ---------------- reference model helpers ----------------
  function automatic logic in_rng(input int x, input int lo, input int hi);
    return (x >= lo) && (x <= hi);
  endfunction

  function automatic logic is_tick(input int n);
    return ((n - base) % CPU) == (CPU - 1);
  endfunction

  // cycle of the k-th usec tick at or after cycle x
  function automatic int kth_tick(input int x, input int k);
    int ph;
    ph = (x - base) % CPU;
    return x + (CPU - 1 - ph) + (k - 1) * CPU;
  endfunction

  // Randomized segment: each channel is modelled as a timestamped window
  // (frame cycle, first ACTIVE cycle, last ACTIVE cycle).
  task automatic rand_seg(input int seg, input int ncyc);
    int w_f[NCH], w_a[NCH], w_e[NCH], p_a[NCH], p_e[NCH];
    int dec_seen, tick_k, exp_cnt, n, d, e, nerr0, nfr, per;
    logic exp_fs, tk, isync, sync, fire, bz;
    logic [NCH-1:0] exp_ovr, ovr_nxt, q_exp;
    nerr0 = err_cnt; nfr = 0;
    do_reset();
    mode_internal = 1'($urandom_range(0, 1));
    per = $urandom_range(1, 5);
    period_usec = EW'(per);
    imu_decim = DW'($urandom_range(0, 3));
    for (int i = 0; i < NCH; i++) begin
      rand_ch(i);
      w_f[i] = -1000; w_a[i] = -1000; w_e[i] = -1000;
      p_a[i] = -1000; p_e[i] = -1000;
    end
    dec_seen = 0; tick_k = 0; exp_cnt = 0; exp_fs = 1'b0; exp_ovr = '0;
    for (int k = 0; k < ncyc; k++) begin
      n = cyc;
      q_exp = '0; bz = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        q_exp[i] = in_rng(n, w_a[i] + 1, w_e[i] + 1) || in_rng(n, p_a[i] + 1, p_e[i] + 1);
        bz = bz | in_rng(n, w_f[i] + 1, w_e[i]);
      end
      chk("rnd_q", 32'(q), 32'(q_exp));
      chk("rnd_frame_start", 32'(frame_start), 32'(exp_fs));
      chk("rnd_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
      chk("rnd_overrun", 32'(overrun), 32'(exp_ovr));
      chk("rnd_busy", 32'(busy), 32'(bz));

      imu_sync = ($urandom_range(0, 3) == 0);
      overrun_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) rand_ch($urandom_range(0, NCH - 1));
      if ($urandom_range(0, 63) == 0) imu_decim = DW'($urandom_range(0, 3));

      for (int i = 0; i < NCH; i++) begin
        ovr_nxt[i] = exp_ovr[i];
        if (exp_fs && in_rng(n, w_f[i] + 1, w_e[i])) begin
          ovr_nxt[i] = 1'b1;
        end else begin
          if (overrun_clr) ovr_nxt[i] = 1'b0;
          d = int'(delay_usec[i*EW +: EW]);
          e = int'(exposure_usec[i*EW +: EW]);
          if (exp_fs && ch_en[i] && e != 0) begin
            p_a[i] = w_a[i]; p_e[i] = w_e[i];
            w_f[i] = n;
            w_a[i] = (d == 0) ? n + 1 : kth_tick(n + 1, d) + 1;
            w_e[i] = kth_tick(w_a[i], e);
          end
        end
      end

      tk = is_tick(n);
      if (tk) tick_k++;
      isync = tk && ((tick_k % per) == 0);
      sync = mode_internal ? isync : imu_sync;
      fire = sync && (dec_seen >= int'(imu_decim));
      if (sync) dec_seen = fire ? 0 : dec_seen + 1;
      exp_fs = fire;
      if (fire) begin
        exp_cnt = (exp_cnt + 1) % 65536;
        nfr++;
      end
      exp_ovr = ovr_nxt;
      @(negedge c);
    end
    $display("random segment %0d: mode_internal=%0d period=%0d frames=%0d new_errors=%0d",
             seg, mode_internal, per, nfr, err_cnt - nerr0);
  endtask

  // ---------------- table of single-frame channel-0 vectors ----------------
  typedef struct {
    logic en;
    int   d;
    int   e;
    int   rise_lo;
    int   rise_hi;
    int   w_lo;
    int   w_hi;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int   s, act, sc[10], rise[NCH], lastfs;
    logic seen12;

    // rise offset measured from the cycle imu_sync is high; -1 = never rises
    tbl[0] = '{1'b1, 0, 3,  3,  3, 11, 15};
    tbl[1] = '{1'b1, 1, 2,  4,  8,  6, 10};
    tbl[2] = '{1'b1, 2, 1,  9, 13,  1,  5};
    tbl[3] = '{1'b1, 4, 2, 19, 23,  6, 10};
    tbl[4] = '{1'b0, 0, 3, -1, -1,  0,  0};
    tbl[5] = '{1'b1, 3, 0, -1, -1,  0,  0};

    do_reset();
    chk("reset_q", 32'(q), 32'h0);
    chk("reset_frame_cnt", 32'(frame_cnt), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      set_ch(0, tbl[v].en, tbl[v].d, tbl[v].e);
      clr_meas();
      sample0();
      imu_sync = 1'b1;
      s = cyc;
      repeat (40) begin
        @(negedge c);
        imu_sync = 1'b0;
        sample0();
      end
      act = (m_rise < 0) ? -1 : m_rise - s;
      chk_rng("tbl_rise", act, tbl[v].rise_lo, tbl[v].rise_hi);
      chk_rng("tbl_width", m_lastw, tbl[v].w_lo, tbl[v].w_hi);
      chk("tbl_frame_cnt", 32'(frame_cnt), 32'd1);
      chk("tbl_overrun", 32'(overrun), 32'h0);
      $display("vector %0d: en=%0d delay=%0d exp=%0d rise=%0d width=%0d",
               v, tbl[v].en, tbl[v].d, tbl[v].e, act, m_lastw);
    end

    // decimation by 3, nine IMU pulses
    do_reset();
    imu_decim = 8'd2;
    set_ch(0, 1'b1, 0, 3);
    clr_meas();
    for (int p = 1; p <= 9; p++) begin
      @(negedge c);
      sample0();
      imu_sync = 1'b1;
      sc[p] = cyc;
      repeat (24) begin
        @(negedge c);
        imu_sync = 1'b0;
        sample0();
      end
      chk("dec_nfs", 32'(m_nfs), 32'(p / 3));
      if (p % 3 == 0) begin
        chk("dec_fs_cycle", 32'(m_lastfs - sc[p]), 32'd1);
        chk_rng("dec_width", m_lastw, 11, 15);
        chk("dec_npulse", 32'(m_nrise), 32'(p / 3));
      end
      if (p == 3) chk("dec_first_rise", 32'(m_rise - sc[3]), 32'd3);
    end
    chk("dec_frame_cnt", 32'(frame_cnt), 32'd3);
    $display("decimation sequence: frames=%0d frame_cnt=%0d", m_nfs, frame_cnt);

    // four channels with staggered delays
    do_reset();
    for (int i = 0; i < NCH; i++) rise[i] = -1;
    set_ch(0, 1'b1, 0, 2); set_ch(1, 1'b1, 1, 2);
    set_ch(2, 1'b1, 2, 2); set_ch(3, 1'b1, 4, 2);
    imu_sync = 1'b1;
    s = cyc;
    repeat (40) begin
      @(negedge c);
      imu_sync = 1'b0;
      for (int i = 0; i < NCH; i++) if (q[i] && rise[i] < 0) rise[i] = cyc;
    end
    chk("stag_rise0", 32'(rise[0] - s), 32'd3);
    chk_rng("stag_rise1", rise[1] - rise[0], 1, 9);
    chk_rng("stag_rise2", rise[2] - rise[0], 6, 14);
    chk_rng("stag_rise3", rise[3] - rise[0], 16, 24);
    chk("stag_order", 32'(rise[0] < rise[1] && rise[1] < rise[2] && rise[2] < rise[3]), 32'd1);
    $display("staggered channels: rise offsets %0d %0d %0d %0d",
             rise[0] - s, rise[1] - s, rise[2] - s, rise[3] - s);

    // overrun set, clear, and set/clear collision
    do_reset();
    set_ch(0, 1'b1, 0, 10);
    set_ch(1, 1'b1, 0, 0);
    set_ch(2, 1'b0, 0, 5);
    clr_meas();
    seen12 = 1'b0;
    for (int k = 0; k <= 70; k++) begin
      if (k > 0) @(negedge c);
      sample0();
      seen12 = seen12 | q[1] | q[2];
      case (k)
        0:  imu_sync = 1'b1;
        1:  imu_sync = 1'b0;
        20: imu_sync = 1'b1;
        21: begin imu_sync = 1'b0; chk("ovr_before", 32'(overrun[0]), 32'd0); end
        22: chk("ovr_set", 32'(overrun[0]), 32'd1);
        24: overrun_clr = 1'b1;
        25: begin overrun_clr = 1'b0; chk("ovr_clr", 32'(overrun[0]), 32'd0); end
        30: imu_sync = 1'b1;
        31: begin imu_sync = 1'b0; overrun_clr = 1'b1; end
        32: begin overrun_clr = 1'b0; chk("ovr_set_wins", 32'(overrun[0]), 32'd1); end
        40: chk("ovr_busy", 32'(busy), 32'd1);
        default: ;
      endcase
    end
    chk("ovr_npulse", 32'(m_nrise), 32'd1);
    chk_rng("ovr_width", m_lastw, 46, 50);
    chk("ovr_other_q", 32'(seen12), 32'd0);
    chk("ovr_other_flags", 32'(overrun[2:1]), 32'd0);
    $display("overrun sequence: pulses=%0d width=%0d", m_nrise, m_lastw);

    // internal period timer, imu_sync ignored
    do_reset();
    mode_internal = 1'b1;
    period_usec = 16'd4;
    lastfs = -1;
    clr_meas();
    repeat (130) begin
      @(negedge c);
      imu_sync = 1'($urandom_range(0, 1));
      if (frame_start) begin
        if (lastfs >= 0) chk("int_period", 32'(cyc - lastfs), 32'd20);
        lastfs = cyc;
        m_nfs++;
      end
    end
    chk("int_count", 32'(m_nfs >= 5), 32'd1);
    period_usec = '0;
    repeat (5) @(negedge c);
    clr_meas();
    repeat (100) begin
      @(negedge c);
      imu_sync = 1'($urandom_range(0, 1));
      sample0();
    end
    chk("int_disabled", 32'(m_nfs), 32'd0);
    imu_sync = 1'b0;
    $display("internal timer: period 4 and period 0 checked");

    // asynchronous reset in the middle of a pulse
    do_reset();
    set_ch(0, 1'b1, 0, 10);
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) @(negedge c);
      imu_sync = (k == 0 || k == 8);
    end
    chk("rst_pre_q", 32'(q[0]), 32'd1);
    chk("rst_pre_ovr", 32'(overrun[0]), 32'd1);
    chk("rst_pre_cnt", 32'(frame_cnt), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_q", 32'(q), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_async_ovr", 32'(overrun), 32'd0);
    @(negedge c);
    rst_n = 1'b1;
    base = cyc;
    clr_meas();
    sample0();
    imu_sync = 1'b1;
    s = cyc;
    repeat (60) begin
      @(negedge c);
      imu_sync = 1'b0;
      sample0();
    end
    chk("rst_after_rise", 32'(m_rise - s), 32'd3);
    chk_rng("rst_after_width", m_lastw, 46, 50);
    chk("rst_after_cnt", 32'(frame_cnt), 32'd1);
    $display("mid-pulse reset: recovered rise offset %0d", m_rise - s);

    // randomized segments against the timestamp model
    for (int sgi = 0; sgi < 6; sgi++) rand_seg(sgi, 400);

    // frame counter wrap with channel 1 enabled but zero exposure
    do_reset();
    set_ch(1, 1'b1, 0, 0);
    imu_sync = 1'b1;
    repeat (65535) @(negedge c);
    imu_sync = 1'b0;
    chk("wrap_ffff", 32'(frame_cnt), 32'hFFFF);
    @(negedge c);
    imu_sync = 1'b1;
    @(negedge c);
    imu_sync = 1'b0;
    @(negedge c);
    chk("wrap_zero", 32'(frame_cnt), 32'h0);
    chk("wrap_ovr1", 32'(overrun[1]), 32'd0);
    chk("wrap_q1", 32'(q[1]), 32'd0);
    chk("wrap_busy", 32'(busy), 32'd0);
    $display("frame counter wrap: frame_cnt=%0h", frame_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
